alu_dispatch: RTL and testbench
===============================

Name: alu_dispatch

Overview:
- Upstream issue stage for the `alu` block.
- Buffers operand/command requests from a producer in a small FIFO and issues them one at a time to the ALU using the ALU's ready/valid protocol.
- Captures each ALU result into an output register that a downstream consumer drains with a valid/ready handshake.
- Tags each result with its command and flags ALU hangs through a watchdog.

Parameters:
- WIDTH, 32, operand/result width.
- DEPTH, 4, request FIFO entries; power of two, minimum 2.
- CMD_W, 4, command width; matches the ALU `i_cmd`.
- TIMEOUT, 64, cycles to wait for ALU `o_valid` after issue before abandoning the operation.

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset (reset==0 clears all state immediately).
- in_a  in  WIDTH  operand A from producer.
- in_b  in  WIDTH  operand B from producer.
- in_cmd  in  CMD_W  opcode (OP_* from alu_defs).
- in_valid  in  1  producer request valid.
- in_ready  out  1  FIFO not full; a transfer occurs when in_valid&&in_ready.
- alu_a  out  WIDTH  to ALU i_a.
- alu_b  out  WIDTH  to ALU i_b.
- alu_cmd  out  CMD_W  to ALU i_cmd; OP_NOP except during the issue cycle.
- alu_result  in  WIDTH  from ALU o_result.
- alu_valid  in  1  from ALU o_valid; result is valid in the cycle it is high.
- alu_ready  in  1  from ALU o_ready; ALU can accept a command.
- out_result  out  WIDTH  registered result.
- out_cmd  out  CMD_W  opcode that produced out_result.
- out_valid  out  1  output register holds data.
- out_ready  in  1  consumer accepts; a transfer occurs when out_valid&&out_ready.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- timeout_err  out  1  sticky; set when an issued operation exceeds TIMEOUT.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, out_result=0, out_cmd=OP_NOP.
  - alu_a=0, alu_b=0, alu_cmd=OP_NOP.
  - fifo_count=0, timeout_err=0.
  - FSM=IDLE; FIFO pointers=0.
- FIFO:
  - Circular buffer with rd/wr pointers of $clog2(DEPTH)+1 bits; MSB distinguishes full from empty.
  - in_ready = !full. A write while full is impossible by protocol.
  - Simultaneous push and pop when full is not possible (in_ready=0). When empty, a push is visible to the FSM the next cycle; there is no fall-through.
  - Requests with in_cmd==OP_NOP are accepted but not written (dropped).
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE -> ISSUE when all hold: FIFO non-empty, alu_ready==1, and the output register is free (out_valid==0, or out_valid&&out_ready this cycle).
  - ISSUE lasts one cycle:
    - alu_a/alu_b/alu_cmd are driven registered from the FIFO head.
    - The head is popped at the end of the cycle and the command is latched into cmd_hold.
    - The watchdog counter is cleared.
    - Next state is WAIT.
  - WAIT:
    - alu_cmd=OP_NOP; alu_a/alu_b hold their last values.
    - On alu_valid: out_result<=alu_result, out_cmd<=cmd_hold, out_valid<=1, then go to IDLE.
    - Otherwise the counter increments. When it reaches TIMEOUT-1 without alu_valid: timeout_err<=1, no result is produced, go to IDLE.
  - alu_valid seen outside WAIT is ignored.
  - Throughput: at most one operation in flight. Minimum issue-to-issue spacing = 2 cycles + ALU latency.
- Output register:
  - out_valid clears on out_ready, unless a new capture occurs in the same cycle; the capture wins and out_valid stays 1.
  - Data is stable while out_valid&&!out_ready.
- timeout_err is cleared only by reset.
- Reset mid-operation: all state is cleared asynchronously; in-flight and buffered operations are discarded; alu_cmd returns to OP_NOP immediately.
- Arithmetic: none in this block. Widths pass through unmodified.

Decomposition:
- Shared package/header alu_defs holds:
  - OP_NOP=0, OP_ADD=1, OP_SUB=2, OP_AND=3, OP_OR=4.
  - FSM state encodings ST_IDLE/ST_ISSUE/ST_WAIT.
- One sub-module, alu_req_fifo: parameterized WIDTH*2+CMD_W-wide synchronous FIFO with count/full/empty.
- The FSM, watchdog and output register stay in alu_dispatch.

Test Plan:
- Single ADD: push a=5, b=7, cmd=OP_ADD with ALU ready -> alu_cmd=OP_ADD for exactly 1 cycle; after alu_valid, out_result=12, out_cmd=OP_ADD, out_valid=1.
- Fill FIFO: hold alu_ready=0 and push 5 requests -> in_ready drops after the 4th, fifo_count=4, 5th is not accepted; release alu_ready -> 4 results emitted in push order.
- Backpressure: out_ready=0 with 2 queued ops -> first result held stable, second not issued (alu_cmd stays OP_NOP); raise out_ready -> second issues the next cycle.
- NOP drop: push cmd=OP_NOP then OP_SUB a=10, b=3 -> fifo_count never exceeds 1; single result 7 with out_cmd=OP_SUB.
- Timeout: issue an op and never assert alu_valid -> after 64 WAIT cycles timeout_err=1, out_valid stays 0, FSM returns to IDLE and issues the next queued op.
- Async reset mid-WAIT with 3 queued ops: drop reset to 0 between clock edges -> outputs return to reset values immediately; after release, no stale results and fifo_count=0.

Source files
------------

// File: rtl/alu_dispatch_pkg.sv
// Shared definitions for the ALU issue stage: opcode encodings understood by
// the downstream ALU and the dispatch FSM state encodings.
package alu_dispatch_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_dispatch_if.sv
// Bundle of every handshake/bus signal around alu_dispatch.
//   producer side : in_a, in_b, in_cmd, in_valid -> ; <- in_ready
//   ALU side      : alu_a, alu_b, alu_cmd -> ; <- alu_result, alu_valid, alu_ready
//   consumer side : out_result, out_cmd, out_valid -> ; <- out_ready
//   status        : fifo_count, timeout_err
// Modport slave is the dispatch block; master is whatever surrounds it.
interface alu_dispatch_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CMD_W = 4
);

  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic [CMD_W-1:0]         in_cmd;
  logic                     in_valid;
  logic                     in_ready;

  logic [WIDTH-1:0]         alu_a;
  logic [WIDTH-1:0]         alu_b;
  logic [CMD_W-1:0]         alu_cmd;
  logic [WIDTH-1:0]         alu_result;
  logic                     alu_valid;
  logic                     alu_ready;

  logic [WIDTH-1:0]         out_result;
  logic [CMD_W-1:0]         out_cmd;
  logic                     out_valid;
  logic                     out_ready;

  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     timeout_err;

  modport slave (
    input  in_a, in_b, in_cmd, in_valid,
    output in_ready,
    output alu_a, alu_b, alu_cmd,
    input  alu_result, alu_valid, alu_ready,
    output out_result, out_cmd, out_valid,
    input  out_ready,
    output fifo_count, timeout_err
  );

  modport master (
    output in_a, in_b, in_cmd, in_valid,
    input  in_ready,
    input  alu_a, alu_b, alu_cmd,
    output alu_result, alu_valid, alu_ready,
    input  out_result, out_cmd, out_valid,
    output out_ready,
    input  fifo_count, timeout_err
  );

endinterface

// File: rtl/alu_dispatch_req_fifo.sv
// Request FIFO for alu_dispatch: circular buffer with one extra pointer bit
// so full and empty are distinguishable. Head is read combinationally; a
// push becomes visible at the head one cycle later (no fall-through).
//   clk, reset   : clock, async active-low reset (clears pointers)
//   push/push_data : write one entry (caller guarantees !full)
//   pop          : discard head entry (caller guarantees !empty)
//   head         : current head entry
//   count/full/empty : occupancy status
module alu_dispatch_req_fifo #(
  parameter int DW    = 68,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [DW-1:0]          push_data,
  input  logic                   pop,
  output logic [DW-1:0]          head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head  = mem[rd_ptr[AW-1:0]];
  assign count = wr_ptr - rd_ptr;
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_dispatch.sv
// Issue stage in front of the ALU. Buffers requests, issues one at a time,
// captures each result into an output register drained by the consumer, and
// flags an ALU that never answers via a sticky timeout.
//   clk    : system clock
//   reset  : async active-low reset, clears all state immediately
//   bus    : alu_dispatch_if.slave (producer, ALU and consumer channels,
//            fifo_count and timeout_err status)
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for a queued request, ALU ready and free output reg
// ST_ISSUE | command on alu_* for one cycle; head popped at end of cycle
// ST_WAIT  | waiting for alu_valid; watchdog running
module alu_dispatch
  import alu_dispatch_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 4,
  parameter int CMD_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          reset,
  alu_dispatch_if.slave bus
);

  localparam int DW   = 2 * WIDTH + CMD_W;
  localparam int WD_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  localparam logic [CMD_W-1:0] CMD_NOP = CMD_W'(OP_NOP);
  localparam logic [WD_W-1:0]  WD_LOAD = WD_W'(TIMEOUT - 1);
  localparam logic [WD_W-1:0]  WD_ONE  = 1;

  state_e state;
  state_e state_nxt;

  logic [DW-1:0]    fifo_head;
  logic [WIDTH-1:0] head_a;
  logic [WIDTH-1:0] head_b;
  logic [CMD_W-1:0] head_cmd;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;

  logic             out_free;
  logic             issue_ok;
  logic             load_issue;
  logic             pop;
  logic             capture;
  logic             wd_expire;

  logic [WD_W-1:0]  wd_cnt;
  logic [CMD_W-1:0] cmd_hold;

  logic [WIDTH-1:0] alu_a_q;
  logic [WIDTH-1:0] alu_b_q;
  logic [CMD_W-1:0] alu_cmd_q;
  logic [WIDTH-1:0] out_result_q;
  logic [CMD_W-1:0] out_cmd_q;
  logic             out_valid_q;
  logic             timeout_err_q;

  // NOP requests complete the handshake but never occupy a slot.
  assign push          = bus.in_valid && !fifo_full && (bus.in_cmd != CMD_NOP);
  assign bus.in_ready  = !fifo_full;

  alu_dispatch_req_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_req_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data ({bus.in_a, bus.in_b, bus.in_cmd}),
    .pop       (pop),
    .head      (fifo_head),
    .count     (bus.fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign {head_a, head_b, head_cmd} = fifo_head;

  // Output register counts as free if it is being drained this very cycle.
  assign out_free = !out_valid_q || bus.out_ready;
  assign issue_ok = !fifo_empty && bus.alu_ready && out_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (issue_ok) state_nxt = ST_ISSUE;
      ST_ISSUE: state_nxt = ST_WAIT;
      ST_WAIT:  if (bus.alu_valid || (wd_cnt == '0)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    load_issue = 1'b0;
    pop        = 1'b0;
    capture    = 1'b0;
    wd_expire  = 1'b0;
    unique case (state)
      ST_IDLE:  load_issue = issue_ok;
      ST_ISSUE: pop = 1'b1;
      ST_WAIT: begin
        capture   = bus.alu_valid;
        wd_expire = !bus.alu_valid && (wd_cnt == '0);
      end
      default: ;
    endcase
  end

  // ALU drive registers: loaded from the head on the way into ISSUE so the
  // command appears exactly during ISSUE; operands then hold through WAIT.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_cmd_q <= CMD_NOP;
    end else if (load_issue) begin
      alu_a_q   <= head_a;
      alu_b_q   <= head_b;
      alu_cmd_q <= head_cmd;
    end else if (state == ST_ISSUE) begin
      alu_cmd_q <= CMD_NOP;
    end
  end

  // Watchdog counts down from TIMEOUT-1; expiry on the WAIT cycle it hits 0
  // gives TIMEOUT WAIT cycles in total.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wd_cnt   <= '0;
      cmd_hold <= CMD_NOP;
    end else if (pop) begin
      wd_cnt   <= WD_LOAD;
      cmd_hold <= head_cmd;
    end else if ((state == ST_WAIT) && !bus.alu_valid && (wd_cnt != '0)) begin
      wd_cnt   <= wd_cnt - WD_ONE;
    end
  end

  // A capture in the same cycle as a drain keeps out_valid high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_result_q <= '0;
      out_cmd_q    <= CMD_NOP;
      out_valid_q  <= 1'b0;
    end else if (capture) begin
      out_result_q <= bus.alu_result;
      out_cmd_q    <= cmd_hold;
      out_valid_q  <= 1'b1;
    end else if (bus.out_ready) begin
      out_valid_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         timeout_err_q <= 1'b0;
    else if (wd_expire) timeout_err_q <= 1'b1;
  end

  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_cmd     = alu_cmd_q;
  assign bus.out_result  = out_result_q;
  assign bus.out_cmd     = out_cmd_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.timeout_err = timeout_err_q;

endmodule

// File: tb/tb_alu_dispatch.sv
// Directed bench for alu_dispatch with a small ALU stub of configurable
// latency, a table of single operations and hand-written corner sequences.
module tb_alu_dispatch;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 4;
  localparam int CMD_W   = 4;
  localparam int TIMEOUT = 64;

  localparam logic [3:0] C_NOP = 4'd0;
  localparam logic [3:0] C_ADD = 4'd1;
  localparam logic [3:0] C_SUB = 4'd2;
  localparam logic [3:0] C_AND = 4'd3;
  localparam logic [3:0] C_OR  = 4'd4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  alu_dispatch_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CMD_W(CMD_W)) bus ();

  alu_dispatch #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .CMD_W(CMD_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ALU stub
  logic        stub_en    = 1'b0;
  int          stub_lat   = 1;
  logic        stub_valid = 1'b0;
  logic        spur_valid = 1'b0;
  logic [31:0] stub_res   = '0;
  logic [31:0] stub_tmp;

  assign bus.alu_valid  = stub_valid | spur_valid;
  assign bus.alu_result = stub_res;

  initial begin
    forever begin
      @(posedge clk); #2;
      if (stub_en && reset && bus.alu_cmd != C_NOP) begin
        case (bus.alu_cmd)
          C_ADD:   stub_tmp = bus.alu_a + bus.alu_b;
          C_SUB:   stub_tmp = bus.alu_a - bus.alu_b;
          C_AND:   stub_tmp = bus.alu_a & bus.alu_b;
          C_OR:    stub_tmp = bus.alu_a | bus.alu_b;
          default: stub_tmp = '0;
        endcase
        repeat (stub_lat) begin @(posedge clk); #2; end
        stub_res   = stub_tmp;
        stub_valid = 1'b1;
        @(posedge clk); #2;
        stub_valid = 1'b0;
      end
    end
  end

  // Monitor: drained results, issue cycles, peak occupancy
  logic [35:0] got_q[$];
  int          issue_cnt = 0;
  logic [31:0] last_a    = '0;
  logic [31:0] last_b    = '0;
  int          max_cnt   = 0;
  logic        max_clr   = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.out_valid && bus.out_ready) got_q.push_back({bus.out_cmd, bus.out_result});
      if (bus.alu_cmd != C_NOP) begin
        issue_cnt <= issue_cnt + 1;
        last_a    <= bus.alu_a;
        last_b    <= bus.alu_b;
      end
      if (max_clr) max_cnt <= 0;
      else if (int'(bus.fifo_count) > max_cnt) max_cnt <= int'(bus.fifo_count);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cmd   = c;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_out(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.out_valid) begin ok = 1; break; end
      tick();
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_issue(input string name);
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (bus.alu_cmd != C_NOP) begin ok = 1; break; end
      tick();
    end
    check(name, 64'(ok), 64'd1);
  endtask

  task automatic wait_q(input string name, input int target);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      if (got_q.size() >= target) begin ok = 1; break; end
      tick();
    end
    check(name, 64'(ok), 64'd1);
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cmd;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench still running, expected to be done");
    $fatal(1);
  end

  initial begin
    int base;
    int bi;
    int n;
    int bad;

    vecs[0] = '{32'd5,        32'd7,        C_ADD, 32'd12};
    vecs[1] = '{32'd10,       32'd3,        C_SUB, 32'd7};
    vecs[2] = '{32'h0000F0F0, 32'h00000FF0, C_AND, 32'h000000F0};
    vecs[3] = '{32'h0000F000, 32'h0000000F, C_OR,  32'h0000F00F};
    vecs[4] = '{32'hFFFFFFFF, 32'd1,        C_ADD, 32'd0};
    vecs[5] = '{32'd0,        32'd1,        C_SUB, 32'hFFFFFFFF};

    bus.in_a = '0; bus.in_b = '0; bus.in_cmd = C_NOP; bus.in_valid = 1'b0;
    bus.alu_ready = 1'b1;
    bus.out_ready = 1'b0;

    // reset values
    #1 reset = 1'b0;
    #2;
    check("rst_in_ready",    64'(bus.in_ready),    64'd1);
    check("rst_out_valid",   64'(bus.out_valid),   64'd0);
    check("rst_out_result",  64'(bus.out_result),  64'd0);
    check("rst_out_cmd",     64'(bus.out_cmd),     64'(C_NOP));
    check("rst_alu_a",       64'(bus.alu_a),       64'd0);
    check("rst_alu_b",       64'(bus.alu_b),       64'd0);
    check("rst_alu_cmd",     64'(bus.alu_cmd),     64'(C_NOP));
    check("rst_fifo_count",  64'(bus.fifo_count),  64'd0);
    check("rst_timeout_err", 64'(bus.timeout_err), 64'd0);
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
    tick();

    // single operations, output held until drained
    stub_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      stub_lat = 1 + (i % 3);
      push(vecs[i].a, vecs[i].b, vecs[i].cmd);
      bi = issue_cnt;
      wait_out($sformatf("vec%0d_wait", i));
      check($sformatf("vec%0d_result", i), 64'(bus.out_result), 64'(vecs[i].exp));
      check($sformatf("vec%0d_cmd", i),    64'(bus.out_cmd),    64'(vecs[i].cmd));
      check($sformatf("vec%0d_issue_cycles", i), 64'(issue_cnt - bi), 64'd1);
      check($sformatf("vec%0d_alu_a", i), 64'(last_a), 64'(vecs[i].a));
      check($sformatf("vec%0d_alu_b", i), 64'(last_b), 64'(vecs[i].b));
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      check($sformatf("vec%0d_drained", i), 64'(bus.out_valid), 64'd0);
    end

    // fill the FIFO while the ALU is not ready
    stub_lat = 1;
    bus.alu_ready = 1'b0;
    bus.out_ready = 1'b1;
    base = got_q.size();
    push(32'd1, 32'd2, C_ADD);
    push(32'd9, 32'd4, C_SUB);
    push(32'd6, 32'd3, C_AND);
    check("fill_ready_at3", 64'(bus.in_ready), 64'd1);
    push(32'd8, 32'd1, C_OR);
    check("fill_count4", 64'(bus.fifo_count), 64'd4);
    check("fill_ready_full", 64'(bus.in_ready), 64'd0);
    push(32'd100, 32'd1, C_ADD);
    check("fill_5th_rejected", 64'(bus.fifo_count), 64'd4);
    bus.alu_ready = 1'b1;
    wait_q("fill_wait", base + 4);
    repeat (20) tick();
    check("fill_nresults", 64'(got_q.size() - base), 64'd4);
    check("fill_r0", 64'(got_q[base]),     {28'd0, C_ADD, 32'd3});
    check("fill_r1", 64'(got_q[base + 1]), {28'd0, C_SUB, 32'd5});
    check("fill_r2", 64'(got_q[base + 2]), {28'd0, C_AND, 32'd2});
    check("fill_r3", 64'(got_q[base + 3]), {28'd0, C_OR,  32'd9});

    // output backpressure
    stub_lat = 2;
    bus.out_ready = 1'b0;
    base = got_q.size();
    push(32'd20, 32'd5, C_SUB);
    push(32'd3,  32'd4, C_ADD);
    wait_out("bp_wait");
    check("bp_result", 64'(bus.out_result), 64'd15);
    check("bp_cmd",    64'(bus.out_cmd),    64'(C_SUB));
    bi  = issue_cnt;
    bad = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.out_result != 32'd15 || !bus.out_valid || bus.alu_cmd != C_NOP) bad++;
    end
    check("bp_hold_bad_cycles", 64'(bad), 64'd0);
    check("bp_no_issue", 64'(issue_cnt - bi), 64'd0);
    check("bp_queued", 64'(bus.fifo_count), 64'd1);
    bus.out_ready = 1'b1;
    tick();
    check("bp_issue_next", 64'(bus.alu_cmd), 64'(C_ADD));
    check("bp_issue_a",    64'(bus.alu_a),   64'd3);
    wait_q("bp_wait2", base + 2);
    check("bp_r0", 64'(got_q[base]),     {28'd0, C_SUB, 32'd15});
    check("bp_r1", 64'(got_q[base + 1]), {28'd0, C_ADD, 32'd7});

    // NOP requests are dropped
    stub_lat = 1;
    bus.alu_ready = 1'b0;
    max_clr = 1'b1;
    tick();
    max_clr = 1'b0;
    base = got_q.size();
    push(32'd0, 32'd0, C_NOP);
    check("nop_count0", 64'(bus.fifo_count), 64'd0);
    push(32'd10, 32'd3, C_SUB);
    check("nop_count1", 64'(bus.fifo_count), 64'd1);
    tick();
    bus.alu_ready = 1'b1;
    wait_q("nop_wait", base + 1);
    repeat (10) tick();
    check("nop_nresults", 64'(got_q.size() - base), 64'd1);
    check("nop_r0", 64'(got_q[base]), {28'd0, C_SUB, 32'd7});
    check("nop_max_count", 64'(max_cnt), 64'd1);

    // watchdog timeout, then the next queued op still issues
    stub_en = 1'b0;
    base = got_q.size();
    push(32'd1, 32'd1, C_ADD);
    push(32'h30, 32'h0C, C_OR);
    wait_issue("to_issue");
    check("to_issue_cmd", 64'(bus.alu_cmd), 64'(C_ADD));
    n = 0;
    for (int i = 0; i < 200; i++) begin
      tick();
      n++;
      if (n == 1) stub_en = 1'b1;
      if (bus.timeout_err) break;
    end
    check("to_cycles_to_err", 64'(n), 64'd65);
    check("to_err", 64'(bus.timeout_err), 64'd1);
    check("to_no_out_valid", 64'(bus.out_valid), 64'd0);
    check("to_no_result", 64'(got_q.size() - base), 64'd0);
    tick();
    check("to_next_issue", 64'(bus.alu_cmd), 64'(C_OR));
    wait_q("to_wait_next", base + 1);
    check("to_next_result", 64'(got_q[base]), {28'd0, C_OR, 32'h3C});
    check("to_err_sticky", 64'(bus.timeout_err), 64'd1);

    // alu_valid outside WAIT is ignored
    repeat (3) tick();
    spur_valid = 1'b1;
    tick();
    spur_valid = 1'b0;
    check("spur_ignored", 64'(bus.out_valid), 64'd0);

    // async reset in the middle of WAIT with three ops queued
    stub_en = 1'b0;
    bus.alu_ready = 1'b0;
    push(32'd1, 32'd2, C_ADD);
    push(32'd3, 32'd4, C_ADD);
    push(32'd5, 32'd6, C_ADD);
    push(32'd7, 32'd8, C_ADD);
    bus.alu_ready = 1'b1;
    wait_issue("rst_mid_issue");
    tick();
    check("rst_mid_queued", 64'(bus.fifo_count), 64'd3);
    check("rst_mid_alu_a_held", 64'(bus.alu_a), 64'd1);
    #2 reset = 1'b0;
    #1;
    check("rst_mid_fifo_count", 64'(bus.fifo_count),  64'd0);
    check("rst_mid_in_ready",   64'(bus.in_ready),    64'd1);
    check("rst_mid_alu_cmd",    64'(bus.alu_cmd),     64'(C_NOP));
    check("rst_mid_alu_a",      64'(bus.alu_a),       64'd0);
    check("rst_mid_out_valid",  64'(bus.out_valid),   64'd0);
    check("rst_mid_timeout",    64'(bus.timeout_err), 64'd0);
    #20 reset = 1'b1;
    stub_en = 1'b1;
    base = got_q.size();
    bi   = issue_cnt;
    repeat (30) tick();
    check("rst_post_no_results", 64'(got_q.size() - base), 64'd0);
    check("rst_post_no_issue",   64'(issue_cnt - bi),      64'd0);
    check("rst_post_count",      64'(bus.fifo_count),      64'd0);
    push(32'd7, 32'd8, C_ADD);
    wait_q("rst_post_wait", base + 1);
    check("rst_post_result", 64'(got_q[base]), {28'd0, C_ADD, 32'd15});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
